bram_tree_feeder: RTL and testbench

- Upstream issue stage for bram_tree.
- Buffers a stream of incoming keys in a small FIFO and issues each key to the tree as a single-cycle replace (wrt+read) pulse.
- Enforces the tree's settle interval between replaces.
- Returns the evicted top item on a valid/ready output stream, so producers never need to know the tree's timing.

---
 rtl/bram_tree_feeder.sv | 171 +++++++++++++++++
 tb/tb_bram_tree_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tree_feeder.sv
// bram_tree_feeder: buffers incoming keys and issues each one to bram_tree as a
// single-cycle replace (wrt+read) pulse, holding off the next replace until the
// tree has settled. The pre-replace top is returned on a valid/ready stream.
module bram_tree_feeder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            tree_wrt,
  output logic                            tree_read,
  output logic [DATA_WIDTH-1:0]           tree_data,
  input  logic [DATA_WIDTH-1:0]           tree_top,
  output logic                            o_top_stable,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_settle_cnt;

  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_tree_wrt;
  logic                  r_tree_read;
  logic [DATA_WIDTH-1:0] r_tree_data;

  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue_ok;

  // Ready depends on registered occupancy only, so m_ready never reaches s_ready.
  assign w_s_ready  = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = s_valid && w_s_ready;
  assign w_pop      = (r_state == S_ISSUE);
  assign w_issue_ok = (r_count != '0) && (!r_m_valid || m_ready);

  assign s_ready      = w_s_ready;
  assign o_count      = r_count;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign tree_wrt     = r_tree_wrt;
  assign tree_read    = r_tree_read;
  assign tree_data    = r_tree_data;
  assign o_top_stable = (r_state != S_SETTLE);

  // FIFO storage: written on every accepted key, no reset needed.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: one ISSUE cycle, then SETTLE_CYCLES of settle time.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue_ok) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle_cnt == SW'(1)) begin
          w_state_next = w_issue_ok ? S_ISSUE : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Settle counter: loaded as ISSUE closes, counts down through SETTLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_settle_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_settle_cnt <= SW'(SETTLE_CYCLES);
    end else if (r_state == S_SETTLE) begin
      r_settle_cnt <= r_settle_cnt - SW'(1);
    end
  end

  // Tree strobes are registered from the next state so they are high exactly
  // while the FSM sits in ISSUE; tree_data keeps its last value otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tree_wrt  <= 1'b0;
      r_tree_read <= 1'b0;
      r_tree_data <= '0;
    end else begin
      r_tree_wrt  <= (w_state_next == S_ISSUE);
      r_tree_read <= (w_state_next == S_ISSUE);
      if (w_state_next == S_ISSUE) begin
        r_tree_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Output register: captures the pre-replace top as ISSUE closes; a reload on
  // that edge takes priority over the downstream handshake clearing it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (r_state == S_ISSUE) begin
      r_m_valid <= 1'b1;
      r_m_data  <= tree_top;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_tree_feeder.sv
// tb_bram_tree_feeder: scoreboard bench for bram_tree_feeder with a small
// behavioural stand-in for the tree (new top = replaced key + 1000).
module tb_bram_tree_feeder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        tree_wrt;
  logic        tree_read;
  logic [31:0] tree_data;
  logic [31:0] tree_top;
  logic        o_top_stable;
  logic [2:0]  o_count;

  bram_tree_feeder #(
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (3)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .tree_wrt     (tree_wrt),
    .tree_read    (tree_read),
    .tree_data    (tree_data),
    .tree_top     (tree_top),
    .o_top_stable (o_top_stable),
    .o_count      (o_count)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_pulse = -1;
  int          n_pulses = 0;
  int          n_beats = 0;
  bit          exact_spacing = 1'b0;
  bit          toggle_ready = 1'b0;
  bit          pend_upd = 1'b0;
  logic [31:0] pend_val;
  logic [31:0] model_top;
  logic [31:0] exp_issue [$];
  logic [31:0] exp_evict [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: capture pre-edge handshakes, step, then score what the DUT did.
  task automatic tick();
    logic        pv, pmv, pmr;
    logic [31:0] pd, pmd;
    pv  = s_valid && s_ready;
    pd  = s_data;
    pmv = m_valid;
    pmr = m_ready;
    pmd = m_data;
    @(posedge CLK);
    #1;
    cyc++;
    if (pend_upd) begin
      tree_top = pend_val;
      pend_upd = 1'b0;
    end
    if (pv) begin
      exp_issue.push_back(pd);
      exp_evict.push_back(model_top);
      model_top = pd + 32'd1000;
    end
    if (pmv && pmr && !RST) begin
      check_eq("evict_avail", 32'(exp_evict.size() > 0), 1);
      if (exp_evict.size() > 0) check_eq("m_data", pmd, exp_evict.pop_front());
      n_beats++;
    end
    if (pmv && !pmr && !RST) begin
      check_eq("m_valid_hold", m_valid, 1);
      check_eq("m_data_hold", m_data, pmd);
    end
    if (tree_wrt) begin
      check_eq("read_with_wrt", tree_read, 1);
      check_eq("issue_avail", 32'(exp_issue.size() > 0), 1);
      if (exp_issue.size() > 0) check_eq("tree_data", tree_data, exp_issue.pop_front());
      if (last_pulse >= 0) begin
        check_eq("spacing_min", 32'((cyc - last_pulse) >= 4), 1);
        if (exact_spacing) check_eq("spacing_exact", cyc - last_pulse, 4);
      end
      last_pulse = cyc;
      n_pulses++;
      pend_upd = 1'b1;
      pend_val = tree_data + 32'd1000;
    end else begin
      check_eq("read_without_wrt", tree_read, 0);
    end
    if (toggle_ready) m_ready = ~m_ready;
  endtask

  task automatic push_key(input logic [31:0] k);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = k;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = s_ready;
      tick();
    end
    s_valid = 1'b0;
    check_eq("push_accept", acc, 1);
  endtask

  task automatic drain(input string tag, input int limit);
    int i;
    i = 0;
    while (i < limit && (exp_issue.size() != 0 || exp_evict.size() != 0 || m_valid)) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(exp_issue.size() == 0 && exp_evict.size() == 0 && !m_valid), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 1);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_data"}, m_data, 0);
    check_eq({tag, "_tree_wrt"}, tree_wrt, 0);
    check_eq({tag, "_tree_read"}, tree_read, 0);
    check_eq({tag, "_tree_data"}, tree_data, 0);
    check_eq({tag, "_count"}, o_count, 0);
    check_eq({tag, "_stable"}, o_top_stable, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tree_top = 32'd9; model_top = 32'd9;
    repeat (2) tick();
    RST = 1'b0;

    // Reset / idle
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset_outputs("idle");
    end

    // Single replace with tree top preloaded to 9
    last_pulse = -1; exact_spacing = 1'b0; m_ready = 1'b0;
    push_key(32'd100);
    check_eq("single_count", o_count, 1);
    check_eq("single_wrt_early", tree_wrt, 0);
    tick();
    check_eq("single_wrt", tree_wrt, 1);
    check_eq("single_tdata", tree_data, 100);
    tick();
    check_eq("single_wrt_off", tree_wrt, 0);
    check_eq("single_m_valid", m_valid, 1);
    check_eq("single_m_data", m_data, 9);
    check_eq("single_unstable0", o_top_stable, 0);
    tick();
    check_eq("single_unstable1", o_top_stable, 0);
    tick();
    check_eq("single_unstable2", o_top_stable, 0);
    tick();
    check_eq("single_stable", o_top_stable, 1);
    m_ready = 1'b1;
    drain("single_drain", 20);

    // Burst at full rate
    n_pulses = 0; n_beats = 0; last_pulse = -1; exact_spacing = 1'b1;
    push_key(32'd10); push_key(32'd20); push_key(32'd30); push_key(32'd40);
    drain("burst_drain", 80);
    check_eq("burst_pulses", n_pulses, 4);
    check_eq("burst_beats", n_beats, 4);
    check_eq("burst_count", o_count, 0);
    exact_spacing = 1'b0;

    // Backpressure: output register stalls, FIFO fills, sixth key refused
    n_pulses = 0; n_beats = 0; last_pulse = -1; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_key(32'd200 + 32'(i));
    s_valid = 1'b1; s_data = 32'd299;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_s_ready", s_ready, 0);
      check_eq("bp_count", o_count, 4);
    end
    s_valid = 1'b0;
    check_eq("bp_pulses", n_pulses, 1);
    check_eq("bp_queued", exp_issue.size(), 4);
    m_ready = 1'b1;
    drain("bp_drain", 100);
    check_eq("bp_pulses_after", n_pulses, 5);
    check_eq("bp_beats", n_beats, 5);

    // Reset in the middle of SETTLE
    n_pulses = 0; last_pulse = -1; m_ready = 1'b1;
    push_key(32'd500);
    push_key(32'd600);
    for (int i = 0; i < 20 && n_pulses == 0; i++) tick();
    check_eq("rst_first_pulse", n_pulses, 1);
    tick();
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    exp_issue.delete();
    exp_evict.delete();
    model_top = tree_top;
    last_pulse = -1;
    repeat (2) tick();
    RST = 1'b0;
    n_pulses = 0;
    repeat (10) tick();
    check_eq("rst_no_stale_issue", n_pulses, 0);
    check_eq("rst_count", o_count, 0);
    push_key(32'd700);
    drain("rst_after_drain", 40);
    check_eq("rst_after_pulses", n_pulses, 1);

    // Pointer wrap with toggling m_ready
    n_pulses = 0; last_pulse = -1; toggle_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_key(32'h0000_0400 + 32'(i * 3));
    drain("wrap_drain", 400);
    toggle_ready = 1'b0; m_ready = 1'b1;
    check_eq("wrap_pulses", n_pulses, 12);
    check_eq("wrap_count", o_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
